// File: rtl/led_pattern_seq.sv
// led_pattern_seq
//   Blink-pattern sequencer for the board status LED. A 4-entry table of
//   (on-time, off-time) steps is played in order, once or looped. Durations
//   are counted in ticks of an internal prescaler (TICK_DIV clocks per tick).
//
// Parameters
//   TICK_DIV  clock cycles per duration tick (>= 2)
//   DUR_W     width of on/off durations, in ticks
//
// Ports
//   clk       system clock, rising edge
//   R         synchronous active-high reset
//   cfg_we    write table[cfg_addr] = {cfg_on, cfg_off}; ignored while busy
//   cfg_addr  table entry to write
//   cfg_on    on-time in ticks
//   cfg_off   off-time in ticks
//   cfg_len   last step index to play, latched on an accepted start
//   loop      restart at step 0 after the last step, latched on start
//   start     begin playback (ignored while busy, loses to stop)
//   stop      abort playback
//   LED       registered LED drive
//   busy      high while a pattern is playing
//   done      one-cycle pulse on non-looped completion
//   step      index of the step playing, 0 when idle
module led_pattern_seq #(
  parameter int TICK_DIV = 100000,
  parameter int DUR_W    = 10
) (
  input  logic             clk,
  input  logic             R,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [DUR_W-1:0] cfg_on,
  input  logic [DUR_W-1:0] cfg_off,
  input  logic [1:0]       cfg_len,
  input  logic             loop,
  input  logic             start,
  input  logic             stop,
  output logic             LED,
  output logic             busy,
  output logic             done,
  output logic [1:0]       step
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  logic [1:0]       state, state_n;
  logic [1:0]       step_n;
  logic             done_n;
  logic [DUR_W-1:0] tab_on  [4];
  logic [DUR_W-1:0] tab_off [4];
  logic [1:0]       len_q;
  logic             loop_q;
  logic [PW-1:0]    presc;
  logic [DUR_W-1:0] dcnt;
  logic [DUR_W-1:0] dur;
  logic             phase_end;
  logic             accept;

  assign busy   = (state != S_IDLE);
  assign accept = (state == S_IDLE) && start && !stop;

  // A zero duration ends the phase on its first cycle; otherwise the phase
  // ends on the last prescaler count of the last tick, giving dur*TICK_DIV.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch
    // can be inferred on any path through the case below.
    dur       = (state == S_OFF) ? tab_off[step] : tab_on[step];
    phase_end = (dur == '0) ||
                ((presc == PS_LAST) && (dcnt == dur - DUR_W'(1)));
    state_n   = state;
    step_n    = step;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_ON;
          step_n  = 2'd0;
        end
      end
      S_ON: begin
        if (stop) begin
          state_n = S_IDLE;
          step_n  = 2'd0;
        end else if (phase_end) begin
          state_n = S_OFF;
        end
      end
      S_OFF: begin
        if (stop) begin
          state_n = S_IDLE;
          step_n  = 2'd0;
        end else if (phase_end) begin
          if (step < len_q) begin
            state_n = S_ON;
            step_n  = step + 2'd1;
          end else if (loop_q) begin
            state_n = S_ON;
            step_n  = 2'd0;
          end else begin
            state_n = S_IDLE;
            step_n  = 2'd0;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        step_n  = 2'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (R) begin
      state  <= S_IDLE;
      step   <= 2'd0;
      done   <= 1'b0;
      LED    <= 1'b0;
      presc  <= '0;
      dcnt   <= '0;
      len_q  <= 2'd0;
      loop_q <= 1'b0;
      // NOTE: the table is cleared by reset on purpose: a pattern started
      // right after reset must play as all-zero steps, not stale contents.
      for (int i = 0; i < 4; i++) begin
        tab_on[i]  <= '0;
        tab_off[i] <= '0;
      end
    end else begin
      if ((state == S_IDLE) && cfg_we) begin
        tab_on[cfg_addr]  <= cfg_on;
        tab_off[cfg_addr] <= cfg_off;
      end
      if (accept) begin
        len_q  <= cfg_len;
        loop_q <= loop;
      end
      state <= state_n;
      step  <= step_n;
      done  <= done_n;
      // LED is computed for the state being entered so it is valid on the
      // first cycle of each phase with no extra latency.
      LED   <= (state_n == S_ON) && (tab_on[step_n] != '0);
      // Every transition enters a new phase, so the counters restart there.
      if ((state_n != state) || (state_n == S_IDLE)) begin
        presc <= '0;
        dcnt  <= '0;
      end else if (presc == PS_LAST) begin
        presc <= '0;
        dcnt  <= dcnt + DUR_W'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq with TICK_DIV=4.
// A cycle-count reference model (remaining cycles per phase) is compared
// against the DUT on every falling edge; directed scenarios add literal
// per-cycle bitmasks that pin the expected waveforms independently.
module tb_led_pattern_seq;

  localparam int TD = 4;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          R = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = 2'd0;
  logic [DW-1:0] cfg_on = '0;
  logic [DW-1:0] cfg_off = '0;
  logic [1:0]    cfg_len = 2'd0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          LED, busy, done;
  logic [1:0]    step;

  led_pattern_seq #(.TICK_DIV(TD), .DUR_W(DW)) dut (
    .clk(clk), .R(R), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_len(cfg_len), .loop(loop),
    .start(start), .stop(stop), .LED(LED), .busy(busy), .done(done),
    .step(step)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_on [4];
  int m_off[4];
  int m_len = 0, m_step = 0, m_rem = 0;
  bit m_loop = 0, m_busy = 0, m_onph = 0, m_done = 0, m_led = 0;

  function automatic int plen(input int d);
    return (d == 0) ? 1 : d * TD;
  endfunction

  always @(posedge clk) begin
    if (R) begin
      for (int i = 0; i < 4; i++) begin m_on[i] = 0; m_off[i] = 0; end
      m_len = 0; m_loop = 0; m_busy = 0; m_onph = 0; m_done = 0;
      m_step = 0; m_rem = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (cfg_we) begin
          m_on[cfg_addr]  = int'(cfg_on);
          m_off[cfg_addr] = int'(cfg_off);
        end
        if (start && !stop) begin
          m_busy = 1; m_step = 0; m_onph = 1; m_rem = plen(m_on[0]);
          m_len = int'(cfg_len); m_loop = loop;
        end
      end else if (stop) begin
        m_busy = 0; m_step = 0; m_onph = 0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_onph) begin
            m_onph = 0; m_rem = plen(m_off[m_step]);
          end else if (m_step < m_len) begin
            m_step++; m_onph = 1; m_rem = plen(m_on[m_step]);
          end else if (m_loop) begin
            m_step = 0; m_onph = 1; m_rem = plen(m_on[0]);
          end else begin
            m_busy = 0; m_step = 0; m_done = 1;
          end
        end
      end
    end
    m_led = m_busy && m_onph && (m_on[m_step] != 0);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_led",  64'(LED),  64'(m_led));
      check("model_busy", 64'(busy), 64'(m_busy));
      check("model_done", 64'(done), 64'(m_done));
      check("model_step", 64'(step), 64'(m_step));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [63:0] v_led, v_busy, v_done, v_s1, v_s2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int on_t, input int off_t);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_on = DW'(on_t); cfg_off = DW'(off_t);
    tick();
    cfg_we = 1'b0;
  endtask

  // Pulse start, then record outputs for cycles t+1..t+n as bit k of the
  // vectors. At cycle 'inj' a table write of {7,7} and a start are issued.
  task automatic run(input int n, input int inj);
    start = 1'b1;
    tick();
    start = 1'b0;
    v_led = '0; v_busy = '0; v_done = '0; v_s1 = '0; v_s2 = '0;
    for (int k = 1; k <= n; k++) begin
      v_led[k]  = LED;
      v_busy[k] = busy;
      v_done[k] = done;
      v_s1[k]   = (step == 2'd1);
      v_s2[k]   = (step == 2'd2);
      if (k == inj) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_on = DW'(7); cfg_off = DW'(7);
        start = 1'b1;
      end
      tick();
      cfg_we = 1'b0;
      start  = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("reset_out", {60'd0, LED, busy, done, step != 2'd0}, 64'd0);
    R = 1'b0;
    tick();

    // all-zero table: two one-cycle phases, done at t+3
    run(8, 0);
    check("zero_busy", v_busy, 64'h6);
    check("zero_led",  v_led,  64'h0);
    check("zero_done", v_done, 64'h8);

    // single step {2,3}
    wr(0, 2, 3);
    run(24, 0);
    check("s23_led",  v_led,  64'h1FE);
    check("s23_busy", v_busy, 64'h1FFFFE);
    check("s23_done", v_done, 64'h200000);

    // three steps {1,1},{2,0},{0,1}
    wr(0, 1, 1); wr(1, 2, 0); wr(2, 0, 1);
    cfg_len = 2'd2;
    run(28, 0);
    check("multi_led",   v_led,  64'h1FE1E);
    check("multi_step1", v_s1,   64'h3FE00);
    check("multi_step2", v_s2,   64'h7C0000);
    check("multi_done",  v_done, 64'h800000);

    // looped {1,1}, then stop mid-OFF
    cfg_len = 2'd0; loop = 1'b1;
    run(24, 0);
    loop = 1'b0;
    check("loop_led",  v_led,  64'h1E1E1E);
    check("loop_done", v_done, 64'h0);
    repeat (5) tick();
    check("loop_in_off", {62'd0, busy, LED}, 64'h2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_out", {60'd0, LED, busy, done, step != 2'd0}, 64'd0);

    // write and restart during playback are ignored
    run(12, 2);
    check("ign_led",  v_led,  64'h1E);
    check("ign_done", v_done, 64'h200);
    wr(0, 7, 7);
    run(60, 0);
    check("w77_led",  v_led,  64'h1FFFFFFE);
    check("w77_done", v_done, 64'h0200_0000_0000_0000);

    // reset mid-ON clears outputs and table
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_r_on", {62'd0, busy, LED}, 64'h3);
    R = 1'b1;
    tick();
    R = 1'b0;
    check("r_out", {60'd0, LED, busy, done, step != 2'd0}, 64'd0);
    run(8, 0);
    check("r_tab_done", v_done, 64'h8);
    check("r_tab_led",  v_led,  64'h0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 64'(busy), 64'd0);
    tick();
    check("ss_busy2", 64'(busy), 64'd0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      R        = ($urandom_range(0, 999) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      start    = ($urandom_range(0, 7) == 0);
      cfg_we   = !start && ($urandom_range(0, 2) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_on   = DW'($urandom_range(0, 3));
      cfg_off  = DW'($urandom_range(0, 3));
      cfg_len  = 2'($urandom_range(0, 3));
      loop     = ($urandom_range(0, 3) == 0);
      tick();
    end
    R = 1'b0; stop = 1'b0; start = 1'b0; cfg_we = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
